// File: rtl/rv_alu_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rv_alu_mc                                                        |
// | Purpose  : Multi-cycle execute-stage ALU with valid/ready handshakes on    |
// |            both sides and a registered result. Arithmetic, logic and      |
// |            compare ops finish in one cycle. Shifts use an iterative       |
// |            shifter that moves SHIFT_STEP bits per cycle, unless the       |
// |            RV_ALU_BARREL_SHIFT_EN macro is defined. With that macro, a    |
// |            combinational barrel shifter finishes shifts in one cycle.     |
// | Params   : XLEN       - datapath width (32 or 64)                          |
// |            SHIFT_STEP - bits shifted per cycle, power of two, 1..XLEN     |
// | Ports    : clk, rst        - clock (rising), async active-high reset       |
// |            in_valid/ready  - request handshake; op/op_a/op_b are captured |
// |            flush           - abort in-flight op, blocks acceptance        |
// |            out_valid/ready - result handshake                             |
// |            out_result      - registered result                            |
// |            out_flag        - compare outcome (ops 8-13), else result==0   |
// |            busy            - FSM not idle                                 |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module rv_alu_mc #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_flag,
    output logic            busy
);

    localparam int c_SHW = $clog2(XLEN);
    // One extra bit so that SHIFT_STEP == XLEN still fits in the counter width.
    localparam int c_CW  = c_SHW + 1;

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_AND  = 4'd2;
    localparam logic [3:0] c_OP_OR   = 4'd3;
    localparam logic [3:0] c_OP_XOR  = 4'd4;
    localparam logic [3:0] c_OP_SLL  = 4'd5;
    localparam logic [3:0] c_OP_SRL  = 4'd6;
    localparam logic [3:0] c_OP_SRA  = 4'd7;
    localparam logic [3:0] c_OP_SLT  = 4'd8;
    localparam logic [3:0] c_OP_SLTU = 4'd9;
    localparam logic [3:0] c_OP_EQ   = 4'd10;
    localparam logic [3:0] c_OP_NE   = 4'd11;
    localparam logic [3:0] c_OP_GE   = 4'd12;
    localparam logic [3:0] c_OP_GEU  = 4'd13;
    localparam logic [3:0] c_OP_RSV  = 4'd14;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [XLEN-1:0] r_result, w_result_nxt;
    logic            r_flag, w_flag_nxt;

    logic            w_accept;
    logic [c_SHW-1:0] w_amt;
    logic [XLEN-1:0] w_alu_result;
    logic            w_alu_flag;
    logic            w_cmp;
    logic            w_is_cmp;
    logic            w_is_rsv;

    // ------------------------------------------------------------------
    // Handshake and status
    // ------------------------------------------------------------------
    // flush overrides everything, so a flush cycle never accepts a request.
    assign in_ready   = !flush && ((r_state == S_IDLE) ||
                                   ((r_state == S_DONE) && out_ready));
    assign w_accept   = in_valid && in_ready;
    assign out_valid  = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);
    assign out_result = r_result;
    assign out_flag   = r_flag;

    assign w_amt    = op_b[c_SHW-1:0];
    assign w_is_cmp = (op >= c_OP_SLT) && (op <= c_OP_GEU);
    assign w_is_rsv = (op >= c_OP_RSV);

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the live request operands
    // ------------------------------------------------------------------
    always_comb begin
        w_alu_result = '0;
        w_cmp        = 1'b0;
        case (op)
            c_OP_ADD:  w_alu_result = op_a + op_b;
            c_OP_SUB:  w_alu_result = op_a - op_b;
            c_OP_AND:  w_alu_result = op_a & op_b;
            c_OP_OR:   w_alu_result = op_a | op_b;
            c_OP_XOR:  w_alu_result = op_a ^ op_b;
`ifdef RV_ALU_BARREL_SHIFT_EN
            c_OP_SLL:  w_alu_result = op_a << w_amt;
            c_OP_SRL:  w_alu_result = op_a >> w_amt;
            c_OP_SRA:  w_alu_result = $signed(op_a) >>> w_amt;
`endif
            c_OP_SLT:  w_cmp = ($signed(op_a) < $signed(op_b));
            c_OP_SLTU: w_cmp = (op_a < op_b);
            c_OP_EQ:   w_cmp = (op_a == op_b);
            c_OP_NE:   w_cmp = (op_a != op_b);
            c_OP_GE:   w_cmp = !($signed(op_a) < $signed(op_b));
            c_OP_GEU:  w_cmp = !(op_a < op_b);
            default:   w_alu_result = '0;
        endcase

        if (w_is_cmp) begin
            w_alu_result = {{(XLEN-1){1'b0}}, w_cmp};
            w_alu_flag   = w_cmp;
        end else if (w_is_rsv) begin
            w_alu_result = '0;
            w_alu_flag   = 1'b1;
        end else begin
            w_alu_flag   = (w_alu_result == '0);
        end
    end

`ifndef RV_ALU_BARREL_SHIFT_EN
    // ------------------------------------------------------------------
    // Iterative shifter: r_result is the working value while in SHIFT
    // ------------------------------------------------------------------
    localparam logic [c_CW-1:0] c_STEP = c_CW'(SHIFT_STEP);

    logic [c_CW-1:0] r_remaining, w_remaining_nxt;
    logic [3:0]      r_shift_op, w_shift_op_nxt;
    logic [c_CW-1:0] w_step;
    logic [XLEN-1:0] w_shifted;
    logic            w_is_shift;

    assign w_is_shift = (op == c_OP_SLL) || (op == c_OP_SRL) || (op == c_OP_SRA);
    assign w_step     = (r_remaining < c_STEP) ? r_remaining : c_STEP;

    always_comb begin
        case (r_shift_op)
            c_OP_SLL: w_shifted = r_result << w_step;
            c_OP_SRL: w_shifted = r_result >> w_step;
            default:  w_shifted = $signed(r_result) >>> w_step;
        endcase
    end
`endif

    // ------------------------------------------------------------------
    // Next-state / next-datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_result_nxt = r_result;
        w_flag_nxt   = r_flag;
`ifndef RV_ALU_BARREL_SHIFT_EN
        w_remaining_nxt = r_remaining;
        w_shift_op_nxt  = r_shift_op;
`endif
        if (flush) begin
            // The held or partial result is dropped. The registers are left as
            // they are, because out_valid already masks them.
            w_state_nxt = S_IDLE;
        end else if (w_accept) begin
`ifndef RV_ALU_BARREL_SHIFT_EN
            if (w_is_shift) begin
                w_result_nxt   = op_a;
                w_flag_nxt     = (op_a == '0);
                w_shift_op_nxt = op;
                if (w_amt == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt     = S_SHIFT;
                    w_remaining_nxt = {1'b0, w_amt};
                end
            end else
`endif
            begin
                w_result_nxt = w_alu_result;
                w_flag_nxt   = w_alu_flag;
                w_state_nxt  = S_DONE;
            end
        end else begin
            case (r_state)
`ifndef RV_ALU_BARREL_SHIFT_EN
                S_SHIFT: begin
                    w_result_nxt    = w_shifted;
                    w_flag_nxt      = (w_shifted == '0);
                    w_remaining_nxt = r_remaining - w_step;
                    // This is the last step when it consumes everything left.
                    if (r_remaining == w_step) begin
                        w_state_nxt = S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_flag   <= 1'b0;
`ifndef RV_ALU_BARREL_SHIFT_EN
            r_remaining <= '0;
            r_shift_op  <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_result <= w_result_nxt;
            r_flag   <= w_flag_nxt;
`ifndef RV_ALU_BARREL_SHIFT_EN
            r_remaining <= w_remaining_nxt;
            r_shift_op  <= w_shift_op_nxt;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv_alu_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_rv_alu_mc                                                     |
// | Purpose  : Self-checking bench for rv_alu_mc (XLEN=32, SHIFT_STEP=4).     |
// |            Directed scenarios plus randomized ops against a behavioural   |
// |            reference model.                                               |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_rv_alu_mc;

    localparam int XLEN = 32;
    localparam int STEP = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            out_flag;
    logic            busy;

    int n_cmp = 0;
    int n_bad = 0;

    rv_alu_mc #(.XLEN(XLEN), .SHIFT_STEP(STEP)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .op_a       (op_a),
        .op_b       (op_b),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flag   (out_flag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: result, flag and expected latency, computed directly from the op rules.
    function automatic void model(input logic [3:0] o, input logic [XLEN-1:0] a,
                                  input logic [XLEN-1:0] b, output logic [XLEN-1:0] r,
                                  output logic f, output int lat);
        int amt;
        amt = int'(b[4:0]);
        r   = '0;
        f   = 1'b0;
        lat = 1;
        case (o)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = a << amt;
            4'd6:  r = a >> amt;
            4'd7:  r = $signed(a) >>> amt;
            4'd8:  f = $signed(a) < $signed(b);
            4'd9:  f = a < b;
            4'd10: f = a == b;
            4'd11: f = a != b;
            4'd12: f = $signed(a) >= $signed(b);
            4'd13: f = a >= b;
            default: f = 1'b1;
        endcase
        if (o <= 4'd7) f = (r == '0);
        else if (o <= 4'd13) r = {{(XLEN-1){1'b0}}, f};
`ifndef RV_ALU_BARREL_SHIFT_EN
        if (o >= 4'd5 && o <= 4'd7 && amt > 0) lat = 1 + (amt + STEP - 1) / STEP;
`endif
    endfunction

    // Issue one op with out_ready high, then check latency, result and flag.
    task automatic run_op(input logic [3:0] o, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input string tag);
        logic [XLEN-1:0] er;
        logic            ef;
        int              el;
        int              lat;
        model(o, a, b, er, ef, el);
        @(negedge clk);
        op = o; op_a = a; op_b = b; in_valid = 1'b1; out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        // Scramble inputs after accept: the captured copy must be used.
        in_valid = 1'b0; op = 4'($urandom); op_a = $urandom; op_b = $urandom;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 64) begin
            check({tag, "_rdy_shift"}, 64'(in_ready), 64'd0);
            @(negedge clk);
            lat++;
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_lat"}, 64'(lat), 64'(el));
        check({tag, "_res"}, 64'(out_result), 64'(er));
        check({tag, "_flag"}, 64'(out_flag), 64'(ef));
    endtask

    initial begin
        logic [3:0]      sc_ops [0:10];
        logic [XLEN-1:0] er;
        logic            ef;
        int              el;
        logic [3:0]      ro;
        logic [XLEN-1:0] ra, rb;
        int              seen;

        sc_ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13};
        rst = 1'b1; in_valid = 1'b0; op = '0; op_a = '0; op_b = '0;
        flush = 1'b0; out_ready = 1'b0;

        // Reset values
        #12;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result", 64'(out_result), 64'd0);
        check("rst_flag", 64'(out_flag), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed ops
        run_op(4'd0, 32'hFFFF_FFFF, 32'h1, "add_wrap");
        run_op(4'd1, 32'd5, 32'd7, "sub_neg");
        run_op(4'd7, 32'h8000_0000, 32'd13, "sra13");
        run_op(4'd8, 32'hFFFF_FFFF, 32'h1, "slt");
        run_op(4'd9, 32'hFFFF_FFFF, 32'h1, "sltu");
        run_op(4'd13, 32'h0, 32'h0, "geu_eq");
        run_op(4'd6, 32'hDEAD_BEEF, 32'h0, "srl_amt0");
        run_op(4'd5, 32'h1, 32'd31, "sll31");
        run_op(4'd14, 32'h1234, 32'h5678, "rsv14");
        run_op(4'd15, 32'h0, 32'h0, "rsv15");

        // Backpressure, then a back-to-back accept on the consuming cycle
        @(negedge clk);
        op = 4'd0; op_a = 32'd3; op_b = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_hold", 64'(out_result), 64'h7);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; op = 4'd4; op_a = 32'hF0; op_b = 32'hFF;
        #1 check("bp_b2b_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp_b2b_valid", 64'(out_valid), 64'd1);
        check("bp_b2b_res", 64'(out_result), 64'h0F);

        // Single-cycle throughput with random ops
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            ro = sc_ops[$urandom_range(0, 10)];
            ra = $urandom; rb = (k % 3 == 0) ? ra : $urandom;
            op = ro; op_a = ra; op_b = rb; in_valid = 1'b1; out_ready = 1'b1;
            #1 check("b2b_in_ready", 64'(in_ready), 64'd1);
            @(posedge clk);
            @(negedge clk);
            model(ro, ra, rb, er, ef, el);
            check("b2b_valid", 64'(out_valid), 64'd1);
            check("b2b_res", 64'(out_result), 64'(er));
            check("b2b_flag", 64'(out_flag), 64'(ef));
        end
        in_valid = 1'b0;

        // Flush during the third cycle after accept (mid-shift when iterative)
        @(negedge clk);
        op = 4'd5; op_a = 32'h1; op_b = 32'd31; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; op = 4'd0;
        #1 check("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_in_ready_after", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_no_valid", 64'(seen), 64'd0);
        run_op(4'd0, 32'd1, 32'd1, "post_flush_add");

        // Asynchronous reset in the middle of an op
        @(negedge clk);
        op = 4'd6; op_a = 32'hFFFF_FFFF; op_b = 32'd20; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("async_valid", 64'(out_valid), 64'd0);
        check("async_busy", 64'(busy), 64'd0);
        check("async_result", 64'(out_result), 64'd0);
        check("async_flag", 64'(out_flag), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("post_rst_in_ready", 64'(in_ready), 64'd1);
        run_op(4'd0, 32'd5, 32'd9, "post_rst_add");

        // Randomized ops of every kind, including reserved and zero shift amounts
        for (int k = 0; k < 80; k++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb[4:0] = 5'd0;
            if ($urandom_range(0, 5) == 0) rb = ra;
            run_op(ro, ra, rb, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/rv_alu_mc.md
# rv_alu_mc

Parametrised multi-cycle ALU: successor to the single-cycle execute-stage ALU. Adds a valid/ready handshake on both sides, a registered result, XLEN generalisation (32/64) and an iterative shifter that trades latency for area. Sits in the execute stage between issue and writeback; branch-target adders stay outside this block.

## Interface
- XLEN, 32, datapath width; 32 or 64 only.
- SHIFT_STEP, 4, bits shifted per cycle in iterative mode; power of two, 1..XLEN.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block accepts the request this cycle.
- op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 EQ, 11 NE, 12 GE, 13 GEU; 14/15 reserved.
- op_a  in  XLEN  operand A.
- op_b  in  XLEN  operand B; shifts use op_b[log2(XLEN)-1:0].
- flush  in  1  abort any in-flight operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_result  out  XLEN  registered result.
- out_flag  out  1  compare outcome for ops 8-13; result==0 otherwise.
- busy  out  1  state != IDLE.

## Operation
- FSM states are IDLE, SHIFT and DONE.
- Accept when in_valid && in_ready. in_ready = !flush && (IDLE || (DONE && out_ready)).
- On accept, op_a, op_b and op are captured. Later input changes have no effect.
- Single-cycle ops (0-4, 8-13): the result is computed and registered at accept, then next state is DONE.
- ADD/SUB wrap modulo 2^XLEN.
- Compare ops: out_result = zero-extended flag. SLT/GE are signed; SLTU/GEU are unsigned.
- Reserved ops: result 0, flag 1, latency 1.
- Shift ops (5-7), iterative mode:
  - Captured amount = 0: next state is DONE with result = op_a.
  - Otherwise, next state is SHIFT. Each cycle shifts by min(remaining, SHIFT_STEP) and decrements remaining.
  - Leave to DONE the cycle remaining reaches 0.
  - SRA fills with the sign bit; SRL and SLL fill with 0.
- DONE: out_valid=1. out_result and out_flag hold stable until out_ready.
- In DONE, if out_ready: go to IDLE, or take a new accept in the same cycle (back-to-back).
- flush, any state: next state is IDLE, out_valid is 0 next cycle, and the result is discarded.
- flush beats in_valid and out_ready in the same cycle: nothing is accepted. A result that is handshaken while flush=1 still counts as consumed.

## Timing
- Reset (async assert) sets state=IDLE, out_valid=0, out_result=0, out_flag=0, busy=0, remaining=0. in_ready is 1 once rst deasserts.
- Latency from accept edge to out_valid:
  - Single-cycle ops: 1 cycle.
  - Shift in iterative mode: 1 + ceil(amt/SHIFT_STEP) cycles.
  - Amt = 0: 1 cycle.
- Throughput: 1 op/cycle for single-cycle ops when out_ready is held high.
- in_ready is low throughout SHIFT, and in DONE while out_ready=0.
- Reset asserted mid-operation: outputs go to reset values immediately (asynchronously). The operation is lost.

## Configuration
- RV_ALU_BARREL_SHIFT_EN defined: shifts use a combinational barrel shifter and complete at accept with latency 1. SHIFT state is unreachable, SHIFT_STEP is ignored, and the remaining counter is not built.
- Not defined: iterative shifter as described above. Area is minimal and latency depends on the shift amount.

## Test plan
- ADD 0xFFFFFFFF + 0x1, out_ready=1 -> out_valid 1 cycle after accept, out_result 0x0, out_flag 1. SUB 5 - 7 -> 0xFFFFFFFE, flag 0.
- SRA 0x80000000 by 13, iterative, STEP=4 -> out_valid 5 cycles after accept, out_result 0xFFFC0000. in_ready is 0 during SHIFT. With the macro defined, the same op gives latency 1.
- SLT 0xFFFFFFFF vs 0x1 -> result 1, flag 1. SLTU with the same operands -> result 0, flag 0. GEU 0x0 vs 0x0 -> flag 1.
- Backpressure: ADD 3+4, then out_ready=0 for 3 cycles -> out_result holds 0x7 and in_ready=0. Then out_ready=1 with in_valid XOR 0xF0^0xFF accepted the same cycle -> next cycle out_result 0x0F.
- Flush: SLL 0x1 by 31 (STEP=4), flush on the 3rd SHIFT cycle -> out_valid never rises, state IDLE and in_ready=1 next cycle. A following ADD 1+1 returns 0x2 with latency 1.
- Reset mid-shift: assert rst during SRL -> out_valid, busy and out_result are 0 without waiting for a clock edge. After release, in_ready=1 and a new op completes normally.
